muldiv_hilo: RTL

Iterative multiply/divide unit with HI/LO architectural registers for the MIPS pipeline, parametrised in data width. It replaces a plain HI/LO register by adding MULT/MULTU/DIV/DIVU execution, MTHI/MTLO single-cycle writes, a start/busy/done handshake and exception cancel. It sits in EX and is read by MFHI/MFLO through hi_o/lo_o.

---
 rtl/muldiv_hilo_pkg.sv | 32 +++
 rtl/muldiv_iter_core.sv | 70 +++++++
 rtl/muldiv_hilo.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/muldiv_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit:
// operation codes, FSM states and op classification helpers.
package muldiv_hilo_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    function automatic logic is_arith(input logic [2:0] o);
        return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic is_div(input logic [2:0] o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iterative datapath on unsigned magnitudes: shift-add multiply
// or restoring divide, one step per enabled edge, with its step counter.
module muldiv_iter_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo,
    output logic             last
);

    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] quo_reg, quo_next;
    logic [WIDTH-1:0] opnd_reg;
    logic [CNT_W-1:0] count_reg;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_rem;
    logic             div_ok;

    // Multiply: {acc,quo} is the running product, quo's LSB selects the add.
    assign mul_sum   = {1'b0, acc_reg} + (quo_reg[0] ? {1'b0, opnd_reg} : '0);
    // Divide: acc is the partial remainder, quo shifts dividend bits out and quotient bits in.
    assign div_shift = {acc_reg, quo_reg[WIDTH-1]};
    assign div_ok    = (div_shift >= {1'b0, opnd_reg});
    assign div_rem   = div_shift[WIDTH-1:0] - opnd_reg;

    always_comb begin
        acc_next = acc_reg;
        quo_next = quo_reg;
        if (div_mode) begin
            acc_next = div_ok ? div_rem : div_shift[WIDTH-1:0];
            quo_next = {quo_reg[WIDTH-2:0], div_ok};
        end else begin
            acc_next = mul_sum[WIDTH:1];
            quo_next = {mul_sum[0], quo_reg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg   <= '0;
            quo_reg   <= '0;
            opnd_reg  <= '0;
            count_reg <= '0;
        end else if (load) begin
            acc_reg   <= '0;
            quo_reg   <= a_mag;
            opnd_reg  <= b_mag;
            count_reg <= '0;
        end else if (step) begin
            acc_reg   <= acc_next;
            quo_reg   <= quo_next;
            count_reg <= count_reg + 1'b1;
        end
    end

    assign acc_hi = acc_reg;
    assign acc_lo = quo_reg;
    assign last   = (count_reg == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/muldiv_hilo.sv
// MIPS HI/LO unit: FSM, operand sign handling, result fix-up, HI/LO
// registers, MTHI/MTLO writes and cancel, around the iterative core.
module muldiv_hilo
    import muldiv_hilo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    state_e state_reg, state_next;

    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic [WIDTH-1:0] dividend_reg;
    logic             div_reg, neg_q_reg, neg_r_reg, dz_reg;

    logic             core_load, core_step, core_last;
    logic             write_hi, write_lo;
    logic             signed_op;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [WIDTH-1:0] fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod_fix;

    assign signed_op = is_signed_op(op);
    assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

    muldiv_iter_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .step     (core_step),
        .div_mode (div_reg),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .acc_hi   (core_hi),
        .acc_lo   (core_lo),
        .last     (core_last)
    );

    always_comb begin
        state_next = state_reg;
        core_load  = 1'b0;
        core_step  = 1'b0;
        write_hi   = 1'b0;
        write_lo   = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start && !cancel) begin
                    if (is_arith(op)) begin
                        core_load  = 1'b1;
                        state_next = ST_CALC;
                    end else if (op == OP_MTHI) begin
                        write_hi = 1'b1;
                    end else if (op == OP_MTLO) begin
                        write_lo = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_next = ST_IDLE;
                end else begin
                    core_step = 1'b1;
                    if (core_last) begin
                        state_next = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
                done       = !cancel;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Sign correction: quotient/product negated on sign mismatch, remainder follows the dividend.
    assign prod_fix = neg_q_reg ? -{core_hi, core_lo} : {core_hi, core_lo};

    always_comb begin
        fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo = prod_fix[WIDTH-1:0];
        if (dz_reg) begin
            fix_hi = dividend_reg;
            fix_lo = '1;
        end else if (div_reg) begin
            fix_hi = neg_r_reg ? -core_hi : core_hi;
            fix_lo = neg_q_reg ? -core_lo : core_lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            hi_reg       <= '0;
            lo_reg       <= '0;
            dividend_reg <= '0;
            div_reg      <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            dz_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (core_load) begin
                dividend_reg <= a;
                div_reg      <= is_div(op);
                neg_q_reg    <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r_reg    <= signed_op && a[WIDTH-1];
                dz_reg       <= is_div(op) && (b == '0);
            end
            if (write_hi) begin
                hi_reg <= a;
            end else if (done) begin
                hi_reg <= fix_hi;
            end
            if (write_lo) begin
                lo_reg <= a;
            end else if (done) begin
                lo_reg <= fix_lo;
            end
        end
    end

    assign busy   = (state_reg != ST_IDLE);
    assign res_hi = done ? fix_hi : '0;
    assign res_lo = done ? fix_lo : '0;
    assign hi_o   = hi_reg;
    assign lo_o   = lo_reg;

endmodule
